// File: rtl/uart_number_receiver.sv
// UART 8N1 receiver with 16x oversampling and an ASCII decimal line parser.
// Each CR/LF-terminated line of digits yields one number or one error pulse.
module uart_number_receiver #(
  parameter int DBITS     = 8,
  parameter int SB_TICK   = 16,
  parameter int BR_LIMIT  = 53,
  parameter int BR_BITS   = 6,
  parameter int NUM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_uart_rx,
  output logic [DBITS-1:0]     o_rx_byte,
  output logic                 o_rx_byte_valid,
  output logic                 o_frame_err,
  output logic [NUM_WIDTH-1:0] o_num,
  output logic                 o_num_valid,
  output logic                 o_num_err,
  output logic                 o_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic                 rx_m;
  logic                 rx_s;
  logic [BR_BITS-1:0]   br_cnt;
  logic                 tick;
  logic [1:0]           state;
  logic [3:0]           s;
  logic [2:0]           n;
  logic [DBITS-1:0]     b;
  logic [NUM_WIDTH-1:0] acc;
  logic                 pending;
  logic                 err;
  logic [NUM_WIDTH+3:0] mac;
  logic                 ovf;
  logic                 is_digit;
  logic                 is_term;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (br_cnt == BR_BITS'(BR_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset)
      br_cnt <= '0;
    else if (tick)
      br_cnt <= '0;
    else
      br_cnt <= br_cnt + 1'b1;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      s               <= '0;
      n               <= '0;
      b               <= '0;
      o_rx_byte       <= '0;
      o_rx_byte_valid <= 1'b0;
      o_frame_err     <= 1'b0;
    end else begin
      o_rx_byte_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            // mid-start-bit recheck rejects short glitches
            if (s == 4'd7) begin
              s <= '0;
              n <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              s <= '0;
              b <= {rx_s, b[DBITS-1:1]};
              if (n == 3'(DBITS - 1))
                state <= STOP;
              else
                n <= n + 3'd1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              state <= IDLE;
              s     <= '0;
              if (rx_s) begin
                o_rx_byte       <= b;
                o_rx_byte_valid <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign is_digit = (o_rx_byte >= DBITS'('h30)) &&
                    (o_rx_byte <= DBITS'('h39));
  assign is_term  = (o_rx_byte == DBITS'('h0D)) ||
                    (o_rx_byte == DBITS'('h0A));

  // acc*10 + d; headroom bits expose overflow
  assign mac = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) +
               (NUM_WIDTH + 4)'(o_rx_byte[3:0]);
  assign ovf = |mac[NUM_WIDTH+3:NUM_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      pending     <= 1'b0;
      err         <= 1'b0;
      o_num       <= '0;
      o_num_valid <= 1'b0;
      o_num_err   <= 1'b0;
    end else begin
      o_num_valid <= 1'b0;
      o_num_err   <= 1'b0;
      if (o_frame_err) begin
        err     <= 1'b1;
        pending <= 1'b1;
      end else if (o_rx_byte_valid) begin
        unique case (1'b1)
          is_digit: begin
            if (ovf)
              err <= 1'b1;
            else
              acc <= mac[NUM_WIDTH-1:0];
            pending <= 1'b1;
          end
          is_term: begin
            if (pending) begin
              if (err) begin
                o_num_err <= 1'b1;
              end else begin
                o_num       <= acc;
                o_num_valid <= 1'b1;
              end
            end
            acc     <= '0;
            pending <= 1'b0;
            err     <= 1'b0;
          end
          default: begin
            err     <= 1'b1;
            pending <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_number_receiver.sv
// Scoreboard bench for uart_number_receiver: 32-bit and 8-bit parser
// instances share one serial line; monitors pop expectations on pulses.
module tb_uart_number_receiver;

  localparam int BR  = 5;
  localparam int BIT = 16 * BR;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } byte_t;

  typedef struct {
    logic        err;
    logic [31:0] val;
  } num_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;

  logic [7:0]  a_byte, b_byte;
  logic        a_bv, b_bv, a_fe, b_fe;
  logic [31:0] a_num;
  logic [7:0]  b_num;
  logic        a_nv, b_nv, a_ne, b_ne;
  logic        a_busy, b_busy;

  byte_t byte_q[$];
  num_t  na_q[$];
  num_t  nb_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  uart_number_receiver #(
    .BR_LIMIT(BR), .NUM_WIDTH(32)
  ) dut_a (
    .clk(clk), .reset(reset), .i_uart_rx(rx),
    .o_rx_byte(a_byte), .o_rx_byte_valid(a_bv),
    .o_frame_err(a_fe), .o_num(a_num),
    .o_num_valid(a_nv), .o_num_err(a_ne),
    .o_busy(a_busy)
  );

  uart_number_receiver #(
    .BR_LIMIT(BR), .NUM_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(reset), .i_uart_rx(rx),
    .o_rx_byte(b_byte), .o_rx_byte_valid(b_bv),
    .o_frame_err(b_fe), .o_num(b_num),
    .o_num_valid(b_nv), .o_num_err(b_ne),
    .o_busy(b_busy)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_bv || a_fe) begin
      if (byte_q.size() == 0) begin
        check("byte_unexpected", {a_fe, a_byte}, 32'hFFFF);
      end else begin
        byte_t e;
        e = byte_q.pop_front();
        check("byte_ferr", 32'(a_fe), 32'(e.ferr));
        if (!e.ferr)
          check("byte_data", 32'(a_byte), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (a_nv || a_ne) begin
      check("a_excl", 32'(a_nv & a_ne), 32'd0);
      if (na_q.size() == 0) begin
        check("a_num_unexpected", a_num, 32'hFFFF_FFFF);
      end else begin
        num_t e;
        e = na_q.pop_front();
        check("a_num_err", 32'(a_ne), 32'(e.err));
        check("a_num", a_num, e.val);
      end
    end
  end

  always @(negedge clk) begin
    if (b_nv || b_ne) begin
      check("b_excl", 32'(b_nv & b_ne), 32'd0);
      if (nb_q.size() == 0) begin
        check("b_num_unexpected", 32'(b_num), 32'hFFFF_FFFF);
      end else begin
        num_t e;
        e = nb_q.pop_front();
        check("b_num_err", 32'(b_ne), 32'(e.err));
        check("b_num", 32'(b_num), e.val);
      end
    end
  end

  task automatic tx(input logic [7:0] c, input bit good_stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = c[i];
      repeat (BIT) @(negedge clk);
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BIT * 5 / 8) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    byte_q.push_back('{ferr: 1'b0, data: c});
    tx(c, 1'b1);
  endtask

  task automatic send_str(input string str);
    for (int i = 0; i < str.len(); i++)
      send_char(str[i]);
  endtask

  task automatic expect_num(input bit ea, input logic [31:0] va,
                            input bit eb, input logic [31:0] vb);
    na_q.push_back('{err: ea, val: va});
    nb_q.push_back('{err: eb, val: vb});
  endtask

  task automatic gap();
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_a_byte", 32'(a_byte), 32'd0);
    check("rst_a_pulses", {a_bv, a_fe, a_nv, a_ne}, 32'd0);
    check("rst_a_num", a_num, 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_num", 32'(b_num), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    reset = 1'b0;
    repeat (BIT) @(negedge clk);

    expect_num(0, 123, 0, 123);
    send_str("123");
    send_char(8'h0D);
    gap();

    expect_num(0, 42, 0, 42);
    send_str("42");
    send_char(8'h0D);
    send_char(8'h0A);
    gap();

    expect_num(1, 42, 1, 42);
    send_str("12a");
    send_char(8'h0D);
    expect_num(0, 7, 0, 7);
    send_str("7");
    send_char(8'h0A);
    gap();

    expect_num(0, 255, 0, 255);
    send_str("255");
    send_char(8'h0D);
    expect_num(0, 256, 1, 255);
    send_str("256");
    send_char(8'h0D);
    expect_num(0, 0, 0, 0);
    send_str("0");
    send_char(8'h0D);
    gap();

    rx = 1'b0;
    repeat (3 * BR) @(negedge clk);
    check("glitch_busy_hi", 32'(a_busy), 32'd1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_busy_lo", 32'(a_busy), 32'd0);

    byte_q.push_back('{ferr: 1'b1, data: 8'h00});
    tx(8'h55, 1'b0);
    expect_num(1, 0, 1, 0);
    send_str("7");
    send_char(8'h0D);
    expect_num(0, 7, 0, 7);
    send_str("7");
    send_char(8'h0D);
    gap();

    send_str("8");
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 8'h35 >> i;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    check("abort_busy_pre", 32'(a_busy), 32'd1);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check("abort_pulses", {a_bv, a_fe, a_nv, a_ne, b_nv, b_ne}, 32'd0);
    check("abort_busy", {a_busy, b_busy}, 32'd0);
    reset = 1'b0;
    gap();

    expect_num(0, 9, 0, 9);
    send_str("9");
    send_char(8'h0D);
    repeat (4 * BIT) @(negedge clk);

    check("byte_q_left", byte_q.size(), 32'd0);
    check("na_q_left", na_q.size(), 32'd0);
    check("nb_q_left", nb_q.size(), 32'd0);
    check("end_busy", {a_busy, b_busy}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
